// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus responder: access direction, FSM states,
// address-decode constants and STATUS register bit positions.
package bus_pkg;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;

    localparam logic [15:0] IO_DATA_OFS = 16'h0000;
    localparam logic [15:0] IO_STAT_OFS = 16'h0001;
    localparam logic [15:0] VEC_LO      = 16'hFFFC;
    localparam logic [15:0] VEC_HI      = 16'hFFFD;

    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [2:0] {
        RGN_VEC_LO, RGN_VEC_HI, RGN_IO_DATA, RGN_IO_STAT, RGN_RAM, RGN_NONE
    } region_t;
endpackage

// File: rtl/io_fifo.sv
// 4-entry first-word-fall-through byte FIFO with a sticky overflow flag that
// is set by a rejected push and cleared on request.
module io_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clr_ovf,
    output logic [7:0] head,
    output logic [2:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       pop_en, push_en;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pop_en   = pop && (count_q != 3'd0);
        // A full FIFO can still take a byte when the head leaves on the same edge.
        push_en  = push && ((count_q != 3'd4) || pop_en);
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push && !push_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == 3'd0);
    assign full     = (count_q == 3'd4);
    assign overflow = ovf_q;
endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the CPU bus: decodes each cycle into RAM, the
// output-port FIFO, the reset vector or unmapped space, with optional wait states.
module bus_responder
    import bus_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                RAM_AW      = 11,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hF000,
    parameter logic [15:0]       RESET_VEC   = 16'h0200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_valid,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_write,
    input  logic [7:0]        data_wr,
    output logic [7:0]        data_rd,
    output logic              ready,
    output logic [7:0]        io_out_data,
    output logic              io_out_valid,
    input  logic              io_out_ready
);
    localparam logic [1:0] WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    function automatic region_t decode(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(VEC_LO))               return RGN_VEC_LO;
        if (a == ADDR_W'(VEC_HI))               return RGN_VEC_HI;
        if (a == IO_BASE + ADDR_W'(IO_DATA_OFS)) return RGN_IO_DATA;
        if (a == IO_BASE + ADDR_W'(IO_STAT_OFS)) return RGN_IO_STAT;
        if ((a >> RAM_AW) == '0)                return RGN_RAM;
        return RGN_NONE;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_rd_q, data_rd_d;
    logic [1:0]        wait_q, wait_d;
    logic              enter_resp;
    region_t           rgn_q, rgn_d;
    logic              ram_we, fifo_push, fifo_clr;
    logic [RAM_AW-1:0] ram_wa, ram_ra;
    logic [7:0]        rd_val;
    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        fifo_head;
    logic [2:0]        fifo_count;
    logic              fifo_empty, fifo_full, fifo_ovf;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (bus_valid) begin
                    addr_d  = address;
                    rw_d    = read_write;
                    wdata_d = data_wr;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wait_d  = WAIT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rgn_q     = decode(addr_q);
    assign rgn_d     = decode(addr_d);
    assign ram_we    = (state_q == RESP) && (rw_q == WRITE) && (rgn_q == RGN_RAM);
    assign fifo_push = (state_q == RESP) && (rw_q == WRITE) && (rgn_q == RGN_IO_DATA);
    assign fifo_clr  = (state_q == RESP) && (rw_q == READ)  && (rgn_q == RGN_IO_STAT);
    assign ram_wa    = addr_q[RAM_AW-1:0];
    assign ram_ra    = addr_d[RAM_AW-1:0];

    // Read data is formed from the request entering RESP; a back-to-back read
    // of the byte being written this cycle must see the new value.
    always_comb begin
        rd_val = 8'hFF;
        case (rgn_d)
            RGN_VEC_LO:  rd_val = RESET_VEC[7:0];
            RGN_VEC_HI:  rd_val = RESET_VEC[15:8];
            RGN_IO_DATA: rd_val = 8'h00;
            RGN_IO_STAT: begin
                rd_val                 = 8'h00;
                rd_val[STAT_OVF_BIT]   = fifo_ovf;
                rd_val[STAT_FULL_BIT]  = fifo_full;
                rd_val[STAT_EMPTY_BIT] = fifo_empty;
            end
            RGN_RAM:     rd_val = (ram_we && (ram_wa == ram_ra)) ? wdata_q : ram[ram_ra];
            default:     rd_val = 8'hFF;
        endcase
        data_rd_d = (enter_resp && (rw_d == READ)) ? rd_val : data_rd_q;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wa] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rw_q      <= READ;
            wdata_q   <= 8'h00;
            wait_q    <= 2'd0;
            data_rd_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            data_rd_q <= data_rd_d;
        end
    end

    io_fifo u_io_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata_q),
        .pop       (io_out_ready),
        .clr_ovf   (fifo_clr),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );

    assign ready        = (state_q == RESP);
    assign data_rd      = data_rd_q;
    assign io_out_data  = fifo_head;
    assign io_out_valid = (fifo_count != 3'd0);
endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: one instance without and one with two wait states,
// checked against a queue/array model of the memory map and output FIFO.
module tb_bus_responder;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid_a, bus_valid_b;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_wr;
    logic        io_out_ready;
    logic [7:0]  data_rd_a, data_rd_b, io_out_data_a, io_out_data_b;
    logic        ready_a, ready_b, io_out_valid_a, io_out_valid_b;

    always #5 clk = ~clk;

    bus_responder #(.WAIT_STATES(0)) u_dut_a (
        .clk(clk), .rst(rst), .bus_valid(bus_valid_a), .address(address),
        .read_write(read_write), .data_wr(data_wr), .data_rd(data_rd_a),
        .ready(ready_a), .io_out_data(io_out_data_a), .io_out_valid(io_out_valid_a),
        .io_out_ready(io_out_ready)
    );

    bus_responder #(.WAIT_STATES(2)) u_dut_b (
        .clk(clk), .rst(rst), .bus_valid(bus_valid_b), .address(address),
        .read_write(read_write), .data_wr(data_wr), .data_rd(data_rd_b),
        .ready(ready_b), .io_out_data(io_out_data_b), .io_out_valid(io_out_valid_b),
        .io_out_ready(io_out_ready)
    );

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] ram_m [2][2048];
    logic [7:0] fifo_a [$];
    logic [7:0] fifo_b [$];
    logic       ovf_m [2];
    logic [7:0] last_rd [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int fifo_size(input int s);
        return (s == 0) ? fifo_a.size() : fifo_b.size();
    endfunction

    function automatic logic [7:0] model_read(input int s, input logic [15:0] a);
        int sz;
        sz = fifo_size(s);
        if (a == 16'hFFFC) return 8'h00;
        if (a == 16'hFFFD) return 8'h02;
        if (a == 16'hF000) return 8'h00;
        if (a == 16'hF001) return {4'b0000, ovf_m[s], sz == 4, sz == 0, 1'b0};
        if (a < 16'd2048)  return ram_m[s][a[10:0]];
        return 8'hFF;
    endfunction

    function automatic void model_push(input int s, input logic [7:0] d);
        if (fifo_size(s) < 4) begin
            if (s == 0) fifo_a.push_back(d);
            else        fifo_b.push_back(d);
        end else begin
            ovf_m[s] = 1'b1;
        end
    endfunction

    function automatic void model_pop_all();
        if (fifo_a.size() != 0) void'(fifo_a.pop_front());
        if (fifo_b.size() != 0) void'(fifo_b.pop_front());
    endfunction

    task automatic checkFifo(input int s);
        int         sz;
        logic [7:0] hd;
        sz = fifo_size(s);
        hd = 8'h00;
        if (sz != 0) hd = (s == 0) ? fifo_a[0] : fifo_b[0];
        checkOutput((s == 0) ? "io_valid_a" : "io_valid_b",
                    (s == 0) ? io_out_valid_a : io_out_valid_b, sz != 0);
        if (sz != 0)
            checkOutput((s == 0) ? "io_data_a" : "io_data_b",
                        (s == 0) ? io_out_data_a : io_out_data_b, hd);
    endtask

    // One isolated access starting and ending at a negedge with the DUT idle.
    task automatic applyStimulus(input int s, input logic [15:0] a, input logic rw,
                                 input logic [7:0] d, input bit pop_in_resp);
        int cycles;
        address    = a;
        read_write = rw;
        data_wr    = d;
        if (s == 0) bus_valid_a = 1'b1;
        else        bus_valid_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_valid_a = 1'b0;
        bus_valid_b = 1'b0;
        address     = 16'($urandom);
        read_write  = 1'($urandom);
        data_wr     = 8'($urandom);
        cycles      = 1;
        while ((((s == 0) ? ready_a : ready_b) !== 1'b1) && (cycles < 8)) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", cycles, (s == 0) ? 1 : 3);
        if (rw == RD) begin
            last_rd[s] = model_read(s, a);
            if (a == 16'hF001) ovf_m[s] = 1'b0;
        end
        checkOutput("data_rd", (s == 0) ? data_rd_a : data_rd_b, last_rd[s]);
        if (pop_in_resp) io_out_ready = 1'b1;
        @(posedge clk);
        if (pop_in_resp) model_pop_all();
        if (rw == WR) begin
            if (a == 16'hF000)     model_push(s, d);
            else if (a < 16'd2048) ram_m[s][a[10:0]] = d;
        end
        @(negedge clk);
        io_out_ready = 1'b0;
        checkOutput("ready_pulse_end", (s == 0) ? ready_a : ready_b, 1'b0);
        checkFifo(s);
    endtask

    task automatic doPop();
        io_out_ready = 1'b1;
        @(posedge clk);
        model_pop_all();
        @(negedge clk);
        io_out_ready = 1'b0;
        checkFifo(0);
        checkFifo(1);
    endtask

    initial begin
        logic [7:0]  old_byte;
        logic [15:0] ra;
        rst = 1'b1; bus_valid_a = 1'b0; bus_valid_b = 1'b0;
        address = 16'h0000; read_write = RD; data_wr = 8'h00; io_out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ovf_m[s]   = 1'b0;
            last_rd[s] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready_a", ready_a, 1'b0);
        checkOutput("rst_ready_b", ready_b, 1'b0);
        checkOutput("rst_data_rd_a", data_rd_a, 8'h00);
        checkOutput("rst_data_rd_b", data_rd_b, 8'h00);
        checkOutput("rst_io_valid_a", io_out_valid_a, 1'b0);
        checkOutput("rst_io_valid_b", io_out_valid_b, 1'b0);
        checkOutput("rst_io_data_a", io_out_data_a, 8'h00);
        checkOutput("rst_io_data_b", io_out_data_b, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("[TB] preloading RAM 0..63");
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++)
                applyStimulus(s, 16'(i), WR, 8'($urandom), 1'b0);

        $display("[TB] back-to-back write/read at 0x0010");
        address = 16'h0010; read_write = WR; data_wr = 8'hA5; bus_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_wr_ready", ready_a, 1'b1);
        address = 16'h0010; read_write = RD; data_wr = 8'h5A;
        @(posedge clk);
        ram_m[0][16] = 8'hA5;
        @(negedge clk);
        bus_valid_a = 1'b0;
        checkOutput("b2b_rd_ready", ready_a, 1'b1);
        checkOutput("b2b_rd_data", data_rd_a, 8'hA5);
        last_rd[0] = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_idle", ready_a, 1'b0);
        applyStimulus(0, 16'h0010, RD, 8'h00, 1'b0);

        $display("[TB] reset vector with wait states");
        applyStimulus(1, 16'hFFFC, RD, 8'h00, 1'b0);
        applyStimulus(1, 16'hFFFD, RD, 8'h00, 1'b0);

        $display("[TB] FIFO overflow and status");
        applyStimulus(0, 16'hF000, WR, 8'h11, 1'b0);
        applyStimulus(0, 16'hF000, WR, 8'h22, 1'b0);
        applyStimulus(0, 16'hF000, WR, 8'h33, 1'b0);
        applyStimulus(0, 16'hF000, WR, 8'h44, 1'b0);
        applyStimulus(0, 16'hF000, WR, 8'h55, 1'b0);
        applyStimulus(0, 16'hF001, RD, 8'h00, 1'b0);
        applyStimulus(0, 16'hF001, RD, 8'h00, 1'b0);
        applyStimulus(0, 16'hF000, WR, 8'h66, 1'b1);
        applyStimulus(0, 16'hF001, RD, 8'h00, 1'b0);
        repeat (4) doPop();

        $display("[TB] unmapped and read-only vector");
        applyStimulus(0, 16'h8000, RD, 8'h00, 1'b0);
        applyStimulus(0, 16'hFFFC, WR, 8'h12, 1'b0);
        applyStimulus(0, 16'hFFFC, RD, 8'h00, 1'b0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 200; n++) begin
            int   s;
            logic rw;
            s = int'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       ra = 16'($urandom_range(0, 63));
                1:       ra = ($urandom_range(0, 1) == 0) ? 16'hFFFC : 16'hFFFD;
                2:       ra = 16'hF000;
                3:       ra = 16'hF001;
                4:       ra = 16'($urandom_range(16'h0800, 16'hEFFF));
                default: ra = 16'($urandom_range(16'hF002, 16'hFFFB));
            endcase
            rw = 1'($urandom_range(0, 1));
            applyStimulus(s, ra, rw, 8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) doPop();
        end

        $display("[TB] reset during a waited RAM write");
        repeat (4) if (fifo_b.size() != 0) doPop();
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'hF000, WR, 8'(8'hC0 + i), 1'b0);
        old_byte = ram_m[1][32];
        address = 16'h0020; read_write = WR; data_wr = ~old_byte; bus_valid_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_valid_b = 1'b0;
        checkOutput("wait_ready", ready_b, 1'b0);
        checkOutput("wait_io_valid", io_out_valid_b, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", ready_b, 1'b0);
        checkOutput("mid_rst_io_valid_b", io_out_valid_b, 1'b0);
        checkOutput("mid_rst_io_valid_a", io_out_valid_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fifo_a.delete();
        fifo_b.delete();
        for (int s = 0; s < 2; s++) begin
            ovf_m[s]   = 1'b0;
            last_rd[s] = 8'h00;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_ready", ready_b, 1'b0);
        checkOutput("post_rst_data_rd", data_rd_b, 8'h00);
        checkFifo(1);
        applyStimulus(1, 16'h0020, RD, 8'h00, 1'b0);
        applyStimulus(1, 16'hF001, RD, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
